dma_ib_frame_arbiter: RTL and testbench
=======================================

// Module: dma_ib_frame_arbiter
// PURPOSE
//  Shares the single inbound DMA stream (dmaIbMaster/dmaIbSlave, 64b) between NUM_SRC frame producers
//  (DAQ event builder, link monitors, ...). Round-robin, frame-atomic grant: a granted source owns the
//  stream until its tLast beat is accepted. A stall watchdog terminates hung frames with an error beat.
// PARAMETERS
//  NUM_SRC      4     number of requesting sources (2..8)
//  DATA_W       64    stream data width
//  TIMEOUT_CYC  4096  consecutive idle cycles mid-frame before forced termination (>=2)
// PORTS
//  dmaClk        in   1               stream clock
//  dmaRst        in   1               sync active-high reset
//  src_enable    in   NUM_SRC         per-source arbitration enable
//  src_valid     in   NUM_SRC         source beat valid
//  src_data      in   NUM_SRC*DATA_W  source data, source i at [i*DATA_W +: DATA_W]
//  src_last      in   NUM_SRC         source end-of-frame
//  src_ready     out  NUM_SRC         beat accepted from source when src_valid&src_ready
//  dma_valid     out  1               to dmaIbMaster_tValid
//  dma_data      out  DATA_W          to dmaIbMaster_tData
//  dma_last      out  1               to dmaIbMaster_tLast
//  dma_dest      out  8               to dmaIbMaster_tDest, = granted source index
//  dma_err       out  1               to dmaIbMaster_tUser[0], 1 only on a forced-termination beat
//  dma_ready     in   1               from dmaIbSlave_tReady
//  grant_idx     out  3               current/last granted source
//  busy          out  1               1 in any state except IDLE
//  frames_sent   out  32              frames completed normally (wraps)
//  timeouts      out  16              forced terminations (saturates at 0xFFFF)
// BEHAVIOUR
//  Reset (dmaRst=1 at edge): state=IDLE, grant_idx=NUM_SRC-1, counters=0, watchdog=0. Combinational
//   outputs dma_valid/src_ready/dma_last/dma_err are 0 in IDLE; dma_data=0, dma_dest=0 outside XFER/TERM.
//   Reset mid-frame abandons the frame with no terminating beat; downstream DMA reset is tied to it.
//  States IDLE, XFER, TERM, FLUSH.
//  IDLE: req = src_valid & src_enable. If req!=0, pick first set bit searching from grant_idx+1 upward,
//   wrapping at NUM_SRC. Register grant_idx, go XFER. No beat passes in the IDLE cycle: 1 cycle
//   arbitration latency.
//  XFER (g=grant_idx): combinational pass-through, 0 latency:
//   dma_valid=src_valid[g], dma_data/dma_last from source g, dma_dest=g, src_ready[g]=dma_ready, others 0.
//   src_enable[g] dropping mid-frame has no effect; the frame completes.
//   Accepted beat with src_last[g] -> frames_sent+1, IDLE.
//   Watchdog: cleared on each accepted beat and on XFER entry; incremented each cycle src_valid[g]=0.
//    Reaching TIMEOUT_CYC -> TERM. dma_ready=0 with src_valid=1 does not count (backpressure).
//  TERM: dma_valid=1, dma_last=1, dma_err=1, dma_data=0, dma_dest=g; all src_ready=0.
//   Held until dma_ready; then timeouts+1 (saturating), watchdog cleared, FLUSH.
//  FLUSH: src_ready[g]=1, dma_valid=0; beats from g are discarded. Accepted src_last[g] -> IDLE.
//   A second TIMEOUT_CYC idle cycles -> IDLE anyway, with no further count.
//  Simultaneous last-beat accept and watchdog expiry: the accept wins (normal completion).
//  The stream protocol is never violated: dma_valid, once high, is not dropped before dma_ready.
//   Guaranteed in XFER only if the source obeys AXIS; TERM holds valid unconditionally.
//  Width: source index uses $clog2(NUM_SRC) bits, zero-extended onto grant_idx/dma_dest.
// TESTING
//  1. Srcs 0,1,2 each send one 3-beat frame at once, dma_ready=1 -> frames ordered 0,1,2;
//     dma_dest 0,1,2; each frame contiguous; frames_sent=3.
//  2. Src 1 sends 5 frames back-to-back, src 3 requesting -> grants alternate 1,3,1,3...; no starvation.
//  3. Src 0 sends 2 beats then stalls, TIMEOUT_CYC=16 -> on the 16th idle cycle enter TERM: beat
//     data=0, last=1, err=1, dest=0; timeouts=1. Late beats from src 0 through its last are
//     swallowed; next grant proceeds.
//  4. dma_ready=0 for 100 cycles mid-frame, source valid held, TIMEOUT_CYC=16 -> no termination;
//     all beats delivered intact.
//  5. dmaRst pulsed during beat 2 of 4 -> next cycle all outputs 0, counters 0, grant_idx=NUM_SRC-1;
//     first request after reset from src 0 granted.
//  6. src_enable[2]=0 with src 2 valid only -> no grant, busy=0; enable dropped mid-frame -> frame
//     completes.

Source files
------------

// File: rtl/dma_ib_frame_arbiter.sv
`default_nettype none
// ==== dma_ib_frame_arbiter: round-robin, frame-atomic sharing of the inbound DMA stream with stall watchdog ====
// ==== Rev 1.0                                                                                              ====
module dma_ib_frame_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      dmaClk,
  input  logic                      dmaRst,
  input  logic [NUM_SRC-1:0]        src_enable,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      dma_valid,
  output logic [DATA_W-1:0]         dma_data,
  output logic                      dma_last,
  output logic [7:0]                dma_dest,
  output logic                      dma_err,
  input  logic                      dma_ready,
  output logic [2:0]                grant_idx,
  output logic                      busy,
  output logic [31:0]               frames_sent,
  output logic [15:0]               timeouts
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_TERM  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]         state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   next_grant;
  logic [WD_W-1:0]    watchdog;
  logic [NUM_SRC-1:0] req;
  logic               found;
  logic               g_valid;
  logic               g_last;
  logic               wd_expired;

  assign req        = src_valid & src_enable;
  assign g_valid    = src_valid[grant];
  assign g_last     = src_last[grant];
  assign wd_expired = (watchdog == WD_LIMIT);
  assign busy       = (state != ST_IDLE);
  assign grant_idx  = 3'(grant);

  // Search starts one past the previous grant so every requester is served in turn.
  always_comb begin
    int cand;
    cand       = 0;
    next_grant = grant;
    found      = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = int'(grant) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!found && req[cand]) begin
        next_grant = IDX_W'(cand);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    dma_valid = 1'b0;
    dma_data  = '0;
    dma_last  = 1'b0;
    dma_err   = 1'b0;
    dma_dest  = '0;
    src_ready = '0;
    case (state)
      ST_XFER: begin
        dma_valid        = g_valid;
        dma_data         = src_data[int'(grant)*DATA_W +: DATA_W];
        dma_last         = g_last;
        dma_dest         = 8'(grant);
        src_ready[grant] = dma_ready;
      end
      ST_TERM: begin
        dma_valid = 1'b1;
        dma_last  = 1'b1;
        dma_err   = 1'b1;
        dma_dest  = 8'(grant);
      end
      ST_FLUSH: begin
        src_ready[grant] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge dmaClk) begin
    if (dmaRst) begin
      state       <= ST_IDLE;
      grant       <= LAST_IDX;
      watchdog    <= '0;
      frames_sent <= '0;
      timeouts    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          watchdog <= '0;
          if (found) begin
            grant <= next_grant;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // A stalled-but-valid source is downstream backpressure, not a hang.
          if (g_valid && dma_ready) begin
            watchdog <= '0;
            if (g_last) begin
              frames_sent <= frames_sent + 32'd1;
              state       <= ST_IDLE;
            end
          end else if (!g_valid) begin
            if (wd_expired) begin
              watchdog <= '0;
              state    <= ST_TERM;
            end else begin
              watchdog <= watchdog + WD_W'(1);
            end
          end
        end
        ST_TERM: begin
          if (dma_ready) begin
            if (timeouts != 16'hFFFF) timeouts <= timeouts + 16'd1;
            watchdog <= '0;
            state    <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (g_valid) begin
            watchdog <= '0;
            if (g_last) state <= ST_IDLE;
          end else if (wd_expired) begin
            watchdog <= '0;
            state    <= ST_IDLE;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_ib_frame_arbiter.sv
`default_nettype none
// ==== tb_dma_ib_frame_arbiter: directed and randomized checks against a frame-level round-robin model ====
// ==== Rev 1.0                                                                                         ====
module tb_dma_ib_frame_arbiter;

  localparam int NS   = 4;
  localparam int DW   = 64;
  localparam int TO   = 16;
  localparam int MAXB = 256;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [7:0]    dest;
    logic          err;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_enable;
  logic [NS-1:0]    src_valid;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_last;
  logic [NS-1:0]    src_ready;
  logic             dma_valid;
  logic [DW-1:0]    dma_data;
  logic             dma_last;
  logic [7:0]       dma_dest;
  logic             dma_err;
  logic             dma_ready;
  logic [2:0]       grant_idx;
  logic             busy;
  logic [31:0]      frames_sent;
  logic [15:0]      timeouts;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] fb_data [NS][MAXB];
  logic          fb_last [NS][MAXB];
  int            fb_len  [NS];
  int            fb_ptr  [NS];
  int            gap     [NS];
  int            serial     = 0;
  int            model_last = NS - 1;
  beat_t         obs_q[$];
  beat_t         exp_q[$];
  int            proto_viol;
  bit            run_timeout;

  dma_ib_frame_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .dmaClk(clk), .dmaRst(rst), .src_enable(src_enable), .src_valid(src_valid),
    .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .dma_valid(dma_valid), .dma_data(dma_data), .dma_last(dma_last), .dma_dest(dma_dest),
    .dma_err(dma_err), .dma_ready(dma_ready), .grant_idx(grant_idx), .busy(busy),
    .frames_sent(frames_sent), .timeouts(timeouts)
  );

  always #5 clk = ~clk;

  task automatic clear_frames();
    for (int s = 0; s < NS; s++) begin
      fb_len[s] = 0; fb_ptr[s] = 0; gap[s] = 0;
    end
  endtask

  task automatic add_frame(input int s, input int len);
    for (int b = 0; b < len; b++) begin
      fb_data[s][fb_len[s]] = {8'(s), 24'(serial), 32'($urandom)};
      fb_last[s][fb_len[s]] = (b == len - 1);
      fb_len[s]++;
      serial++;
    end
  endtask

  // Whole frames are granted in round-robin order among sources that still hold frames.
  task automatic build_expected();
    int    p [NS];
    int    c;
    int    cand;
    bit    any;
    beat_t e;
    exp_q.delete();
    for (int s = 0; s < NS; s++) p[s] = fb_ptr[s];
    for (int f = 0; f < 1000; f++) begin
      any = 0; c = 0;
      for (int k = 1; k <= NS; k++) begin
        cand = (model_last + k) % NS;
        if (!any && p[cand] < fb_len[cand]) begin c = cand; any = 1; end
      end
      if (!any) break;
      for (int b = 0; b < MAXB; b++) begin
        e.data = fb_data[c][p[c]]; e.last = fb_last[c][p[c]]; e.dest = 8'(c); e.err = 1'b0;
        exp_q.push_back(e);
        p[c]++;
        if (e.last) break;
      end
      model_last = c;
    end
  endtask

  task automatic run_traffic(input int ready_pct, input bit gaps_on);
    bit            prev_stall;
    bit            drained;
    logic [DW-1:0] prev_data;
    logic [NS-1:0] acc;
    beat_t         o;
    obs_q.delete(); proto_viol = 0; run_timeout = 1; prev_stall = 0; prev_data = '0;
    src_enable = '1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      for (int s = 0; s < NS; s++) begin
        if (fb_ptr[s] < fb_len[s] && gap[s] == 0) begin
          src_valid[s] = 1'b1;
          src_data[s*DW +: DW] = fb_data[s][fb_ptr[s]];
          src_last[s] = fb_last[s][fb_ptr[s]];
        end else begin
          src_valid[s] = 1'b0; src_data[s*DW +: DW] = '0; src_last[s] = 1'b0;
        end
      end
      dma_ready = (int'($urandom_range(0, 99)) < ready_pct);
      #1;
      if (prev_stall && (!dma_valid || dma_data !== prev_data)) proto_viol++;
      if (dma_valid && dma_ready) begin
        o.data = dma_data; o.last = dma_last; o.dest = dma_dest; o.err = dma_err;
        obs_q.push_back(o);
      end
      prev_stall = dma_valid && !dma_ready;
      prev_data  = dma_data;
      acc = src_valid & src_ready;
      @(posedge clk);
      drained = 1;
      for (int s = 0; s < NS; s++) begin
        if (acc[s]) begin
          fb_ptr[s]++;
          if (gaps_on && fb_ptr[s] < fb_len[s] && !fb_last[s][fb_ptr[s]-1])
            gap[s] = int'($urandom_range(0, 4));
        end else if (gap[s] > 0) begin
          gap[s]--;
        end
        if (fb_ptr[s] < fb_len[s]) drained = 0;
      end
      if (drained) begin run_timeout = 0; break; end
    end
    @(negedge clk);
    src_valid = '0; src_last = '0; src_data = '0; dma_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic compare_stream(output int idx, output beat_t got, output beat_t want);
    int n;
    idx = -1; got = '0; want = '0;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i] !== exp_q[i]) begin idx = i; got = obs_q[i]; want = exp_q[i]; break; end
    end
    if (idx < 0 && obs_q.size() != exp_q.size()) idx = n;
  endtask

  task automatic send_beat(input int s, input logic [DW-1:0] d, input logic l, input logic rdy,
                           output bit ok, output beat_t seen, output bit seen_valid);
    ok = 0; seen = '0; seen_valid = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      src_valid = '0; src_last = '0; src_data = '0;
      src_valid[s] = 1'b1; src_data[s*DW +: DW] = d; src_last[s] = l; dma_ready = rdy;
      #1;
      if (src_ready[s]) begin
        ok = 1; seen_valid = dma_valid;
        seen.data = dma_data; seen.last = dma_last; seen.dest = dma_dest; seen.err = dma_err;
        @(posedge clk);
        break;
      end
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    src_valid = '0; src_last = '0; src_data = '0; dma_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_enable = '1; src_valid = '0; src_last = '0; src_data = '0; dma_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (grant_idx !== 3'(NS - 1)) $display("FAIL reset_grant: got %0d want %0d", grant_idx, NS - 1); else n_pass++;
    n_checks++;
    if (frames_sent !== 32'd0 || timeouts !== 16'd0)
      $display("FAIL reset_counters: got frames=%0d timeouts=%0d want 0/0", frames_sent, timeouts);
    else n_pass++;
    n_checks++;
    if ({dma_valid, dma_last, dma_err, dma_dest, dma_data, src_ready} !== '0)
      $display("FAIL reset_outputs: got valid=%b last=%b err=%b dest=%0d data=%h ready=%b want all 0",
               dma_valid, dma_last, dma_err, dma_dest, dma_data, src_ready);
    else n_pass++;
    model_last = NS - 1;
  endtask

  task automatic test_round_robin();
    int idx; beat_t g; beat_t w; logic [31:0] fs0;
    fs0 = frames_sent;
    clear_frames();
    add_frame(0, 3); add_frame(1, 3); add_frame(2, 3);
    build_expected();
    run_traffic(100, 0);
    compare_stream(idx, g, w);
    n_checks++;
    if (run_timeout) $display("FAIL rr_done: got undrained sources want all drained"); else n_pass++;
    n_checks++;
    if (idx >= 0) $display("FAIL rr_stream: beat %0d got %h want %h (beats got %0d want %0d)",
                           idx, g, w, obs_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (frames_sent !== fs0 + 32'd3) $display("FAIL rr_frames: got %0d want %0d", frames_sent, fs0 + 3); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int idx; beat_t g; beat_t w; logic [31:0] fs0;
    fs0 = frames_sent;
    clear_frames();
    for (int f = 0; f < 5; f++) add_frame(1, int'($urandom_range(1, 4)));
    for (int f = 0; f < 4; f++) add_frame(3, int'($urandom_range(1, 4)));
    build_expected();
    run_traffic(100, 0);
    compare_stream(idx, g, w);
    n_checks++;
    if (run_timeout || idx >= 0)
      $display("FAIL b2b_stream: beat %0d got %h want %h (timeout=%0d beats got %0d want %0d)",
               idx, g, w, run_timeout, obs_q.size(), exp_q.size());
    else n_pass++;
    n_checks++;
    if (frames_sent !== fs0 + 32'd9) $display("FAIL b2b_frames: got %0d want %0d", frames_sent, fs0 + 9); else n_pass++;
  endtask

  task automatic test_random();
    int idx; beat_t g; beat_t w; logic [31:0] fs0; int nfr; int rp;
    for (int it = 0; it < 3; it++) begin
      fs0 = frames_sent; nfr = 0;
      clear_frames();
      for (int s = 0; s < NS; s++) begin
        int k;
        k = int'($urandom_range(0, 4));
        for (int f = 0; f < k; f++) add_frame(s, int'($urandom_range(1, 6)));
        nfr += k;
      end
      rp = int'($urandom_range(40, 100));
      build_expected();
      run_traffic(rp, 1);
      compare_stream(idx, g, w);
      n_checks++;
      if (run_timeout || idx >= 0)
        $display("FAIL rand_stream[%0d]: beat %0d got %h want %h (timeout=%0d beats got %0d want %0d)",
                 it, idx, g, w, run_timeout, obs_q.size(), exp_q.size());
      else n_pass++;
      n_checks++;
      if (proto_viol != 0) $display("FAIL rand_protocol[%0d]: got %0d valid drops want 0", it, proto_viol); else n_pass++;
      n_checks++;
      if (frames_sent !== fs0 + 32'(nfr)) $display("FAIL rand_frames[%0d]: got %0d want %0d", it, frames_sent, fs0 + nfr);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit ok1; bit ok2; bit sv; bit sv2; beat_t sn; beat_t want; int idle; int bad;
    logic [31:0] fs0; logic [15:0] to0; logic [DW-1:0] d;
    fs0 = frames_sent; to0 = timeouts; src_enable = '1;
    send_beat(0, 64'hA0A0_0000_0000_0001, 1'b0, 1'b1, ok1, sn, sv);
    send_beat(0, 64'hA0A0_0000_0000_0002, 1'b0, 1'b1, ok2, sn, sv);
    n_checks++;
    if (!(ok1 && ok2)) $display("FAIL to_first_beats: got accepted=%0d%0d want 11", ok1, ok2); else n_pass++;
    idle = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      src_valid = '0; src_last = '0; src_data = '0; dma_ready = 1'b0;
      #1;
      if (dma_valid) break;
      idle++;
    end
    n_checks++;
    if (idle != TO) $display("FAIL to_idle_cycles: got %0d want %0d", idle, TO); else n_pass++;
    n_checks++;
    if ({dma_valid, dma_last, dma_err, dma_dest, dma_data} !== {1'b1, 1'b1, 1'b1, 8'd0, 64'd0})
      $display("FAIL to_term_beat: got valid=%b last=%b err=%b dest=%0d data=%h want 1/1/1/0/0",
               dma_valid, dma_last, dma_err, dma_dest, dma_data);
    else n_pass++;
    n_checks++;
    if (src_ready !== '0) $display("FAIL to_term_ready: got %b want 0000", src_ready); else n_pass++;
    bad = 0;
    repeat (3) begin @(negedge clk); #1; if (!dma_valid || !dma_err) bad++; end
    n_checks++;
    if (bad != 0) $display("FAIL to_term_hold: got %0d dropped cycles want 0", bad); else n_pass++;
    @(negedge clk); dma_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); dma_ready = 1'b0; #1;
    n_checks++;
    if (timeouts !== to0 + 16'd1) $display("FAIL to_count: got %0d want %0d", timeouts, to0 + 1); else n_pass++;
    n_checks++;
    if (dma_valid !== 1'b0 || busy !== 1'b1 || src_ready !== 4'b0001)
      $display("FAIL to_flush_state: got valid=%b busy=%b ready=%b want 0/1/0001", dma_valid, busy, src_ready);
    else n_pass++;
    send_beat(0, 64'hA0A0_0000_0000_0003, 1'b0, 1'b0, ok1, sn, sv);
    send_beat(0, 64'hA0A0_0000_0000_0004, 1'b1, 1'b0, ok2, sn, sv2);
    n_checks++;
    if (!(ok1 && ok2) || sv || sv2)
      $display("FAIL to_swallow: got accepted=%0d%0d forwarded=%0d%0d want 11/00", ok1, ok2, sv, sv2);
    else n_pass++;
    idle_inputs();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL to_back_idle: got busy=%b want 0", busy); else n_pass++;
    d = {8'h02, 24'(serial), 32'($urandom)}; serial++;
    send_beat(2, d, 1'b1, 1'b1, ok1, sn, sv);
    want.data = d; want.last = 1'b1; want.dest = 8'd2; want.err = 1'b0;
    n_checks++;
    if (!ok1 || !sv || sn !== want) $display("FAIL to_next_grant: got ok=%0d valid=%0d beat=%h want %h", ok1, sv, sn, want);
    else n_pass++;
    idle_inputs();
    n_checks++;
    if (frames_sent !== fs0 + 32'd1) $display("FAIL to_frames: got %0d want %0d", frames_sent, fs0 + 1); else n_pass++;
    model_last = 2;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d [4]; bit ok; bit sv; beat_t sn; int bad; int bad_beats;
    logic [31:0] fs0; logic [15:0] to0;
    fs0 = frames_sent; to0 = timeouts; bad_beats = 0; src_enable = '1;
    for (int i = 0; i < 4; i++) begin d[i] = {8'h01, 24'(serial), 32'($urandom)}; serial++; end
    send_beat(1, d[0], 1'b0, 1'b1, ok, sn, sv);
    if (!ok || !sv || sn !== {d[0], 1'b0, 8'd1, 1'b0}) bad_beats++;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      src_valid = 4'b0010; src_data = '0; src_data[DW +: DW] = d[1]; src_last = '0; dma_ready = 1'b0;
      #1;
      if (!dma_valid || dma_err || dma_data !== d[1] || src_ready !== '0) bad++;
    end
    for (int i = 1; i < 4; i++) begin
      send_beat(1, d[i], (i == 3), 1'b1, ok, sn, sv);
      if (!ok || !sv || sn !== {d[i], (i == 3), 8'd1, 1'b0}) bad_beats++;
    end
    idle_inputs();
    n_checks++;
    if (bad != 0) $display("FAIL bp_stall_hold: got %0d bad stall cycles want 0", bad); else n_pass++;
    n_checks++;
    if (bad_beats != 0) $display("FAIL bp_beats: got %0d corrupted beats want 0", bad_beats); else n_pass++;
    n_checks++;
    if (timeouts !== to0 || frames_sent !== fs0 + 32'd1)
      $display("FAIL bp_counters: got timeouts=%0d frames=%0d want %0d/%0d", timeouts, frames_sent, to0, fs0 + 1);
    else n_pass++;
    model_last = 1;
  endtask

  task automatic test_enable();
    logic [DW-1:0] d [3]; bit ok; bit sv; beat_t sn; int bad; int bad_beats; logic [31:0] fs0;
    fs0 = frames_sent; bad = 0; bad_beats = 0;
    for (int i = 0; i < 3; i++) begin d[i] = {8'h02, 24'(serial), 32'($urandom)}; serial++; end
    src_enable = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      src_valid = 4'b0100; src_data = '0; src_data[2*DW +: DW] = d[0]; src_last = '0; dma_ready = 1'b1;
      #1;
      if (busy || dma_valid || src_ready !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL en_disabled_grant: got %0d granted cycles want 0", bad); else n_pass++;
    src_enable = '1;
    send_beat(2, d[0], 1'b0, 1'b1, ok, sn, sv);
    if (!ok || !sv || sn !== {d[0], 1'b0, 8'd2, 1'b0}) bad_beats++;
    src_enable = 4'b1011;
    for (int i = 1; i < 3; i++) begin
      send_beat(2, d[i], (i == 2), 1'b1, ok, sn, sv);
      if (!ok || !sv || sn !== {d[i], (i == 2), 8'd2, 1'b0}) bad_beats++;
    end
    idle_inputs();
    n_checks++;
    if (bad_beats != 0 || frames_sent !== fs0 + 32'd1 || busy !== 1'b0)
      $display("FAIL en_drop_midframe: got bad=%0d frames=%0d busy=%b want 0/%0d/0", bad_beats, frames_sent, busy, fs0 + 1);
    else n_pass++;
    src_enable = '1;
    model_last = 2;
  endtask

  task automatic test_reset_mid_frame();
    bit ok; bit sv; beat_t sn; logic [DW-1:0] e0; logic [DW-1:0] e1;
    src_enable = '1;
    send_beat(0, 64'hC0C0_0000_0000_0001, 1'b0, 1'b1, ok, sn, sv);
    send_beat(0, 64'hC0C0_0000_0000_0002, 1'b0, 1'b1, ok, sn, sv);
    @(negedge clk);
    src_valid = 4'b0001; src_data = '0; src_data[0 +: DW] = 64'hC0C0_0000_0000_0003; dma_ready = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; src_valid = '0; src_last = '0; src_data = '0; dma_ready = 1'b0;
    #1;
    n_checks++;
    if ({dma_valid, dma_last, dma_err, dma_dest, dma_data, src_ready, busy} !== '0)
      $display("FAIL rstmid_outputs: got valid=%b dest=%0d data=%h ready=%b busy=%b want all 0",
               dma_valid, dma_dest, dma_data, src_ready, busy);
    else n_pass++;
    n_checks++;
    if (frames_sent !== 32'd0 || timeouts !== 16'd0 || grant_idx !== 3'(NS - 1))
      $display("FAIL rstmid_state: got frames=%0d timeouts=%0d grant=%0d want 0/0/%0d",
               frames_sent, timeouts, grant_idx, NS - 1);
    else n_pass++;
    e0 = 64'hD0D0_0000_0000_0000; e1 = 64'hD1D1_0000_0000_0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      src_valid = 4'b0011; src_last = 4'b0011; src_data = '0;
      src_data[0 +: DW] = e0; src_data[DW +: DW] = e1; dma_ready = 1'b1;
      #1;
      if (dma_valid) break;
    end
    n_checks++;
    if (dma_valid !== 1'b1 || dma_dest !== 8'd0 || dma_data !== e0)
      $display("FAIL rstmid_first_grant: got valid=%b dest=%0d data=%h want 1/0/%h", dma_valid, dma_dest, dma_data, e0);
    else n_pass++;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; src_enable = '0; src_valid = '0; src_data = '0; src_last = '0; dma_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_random();
    test_timeout();
    test_backpressure();
    test_enable();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_time_limit: got no completion want finish before limit");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
